// File: rtl/mux_4to1.sv
// 4-to-1 data selector with a combinational output and a registered copy.
// out tracks in0..in3/sel directly; out_q/sel_q hold last cycle's selection.
module mux_4to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q
);

    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] r_out_q;
    logic [1:0]       r_sel_q;

    always_comb begin
        // NOTE: default assigned first so no path leaves w_sel_data unassigned
        // (no latch); a non-binary sel matches no item and yields all-zero.
        w_sel_data = '0;
        case (sel)
            2'b00: w_sel_data = in0;
            2'b01: w_sel_data = in1;
            2'b10: w_sel_data = in2;
            2'b11: w_sel_data = in3;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep register updates order-independent.
        if (!rst_n) begin
            r_out_q <= '0;
            r_sel_q <= 2'b00;
        end else begin
            r_out_q <= w_sel_data;
            r_sel_q <= sel;
        end
    end

    assign out   = w_sel_data;
    assign out_q = r_out_q;
    assign sel_q = r_sel_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 at WIDTH 8, 1 and 32.
// Expected values are queued when stimulus is applied and compared on output.
module tb_mux_4to1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0]  in0, in1, in2, in3, out, out_q;
    logic [1:0]  sel, sel_q;
    logic [0:0]  n_in0, n_in1, n_in2, n_in3, n_out, n_out_q;
    logic [1:0]  n_sel, n_sel_q;
    logic [31:0] w_in0, w_in1, w_in2, w_in3, w_out, w_out_q;
    logic [1:0]  w_sel, w_sel_q;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel),
        .out(out), .out_q(out_q), .sel_q(sel_q)
    );

    mux_4to1 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in0(n_in0), .in1(n_in1), .in2(n_in2), .in3(n_in3), .sel(n_sel),
        .out(n_out), .out_q(n_out_q), .sel_q(n_sel_q)
    );

    mux_4to1 #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in0(w_in0), .in1(w_in1), .in2(w_in2), .in3(w_in3), .sel(w_sel),
        .out(w_out), .out_q(w_out_q), .sel_q(w_sel_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mux(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d,
                                            input logic [1:0] s);
        case (s)
            2'b00: return a;
            2'b01: return b;
            2'b10: return c;
            default: return d;
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    initial begin
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; sel = 2'b00;
        n_in0 = '0; n_in1 = '0; n_in2 = '0; n_in3 = '0; n_sel = 2'b00;
        w_in0 = '0; w_in1 = '0; w_in2 = '0; w_in3 = '0; w_sel = 2'b00;

        // Reset state, before any clock edge.
        #2;
        check("rst_out_q", {24'd0, out_q}, 32'h0);
        check("rst_sel_q", {30'd0, sel_q}, 32'h0);

        // Directed sweep, run while reset is still asserted.
        in0 = 8'h11; in1 = 8'h22; in2 = 8'h33; in3 = 8'h44;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            push($sformatf("sweep_sel%0d", s), 32'h11 * (s + 1));
            #5;
            pop_check({24'd0, out});
        end
        check("rst_hold_out_q", {24'd0, out_q}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Random patterns against the reference model.
        for (int i = 0; i < 16; i++) begin
            in0 = 8'($urandom); in1 = 8'($urandom);
            in2 = 8'($urandom); in3 = 8'($urandom);
            sel = 2'($urandom_range(0, 3));
            push($sformatf("rand%0d", i), ref_mux({24'd0, in0}, {24'd0, in1},
                                                  {24'd0, in2}, {24'd0, in3}, sel));
            #5;
            pop_check({24'd0, out});
        end

        // Registered path: preload out_q with 5A, then select A5.
        @(negedge clk);
        sel = 2'b00; in0 = 8'h5A;
        @(negedge clk);
        sel = 2'b10; in2 = 8'hA5;
        push("reg_out_q", 32'hA5);
        push("reg_sel_q", 32'h2);
        #1;
        check("reg_before_edge", {24'd0, out_q}, 32'h5A);
        @(posedge clk);
        #1;
        pop_check({24'd0, out_q});
        pop_check({30'd0, sel_q});

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_q", {24'd0, out_q}, 32'h0);
        check("async_sel_q", {30'd0, sel_q}, 32'h0);
        check("async_out", {24'd0, out}, 32'hA5);
        sel = 2'b01; in1 = 8'h3C;
        #1;
        check("rst_track_out", {24'd0, out}, 32'h3C);

        // Reset release: capture only at the first rising edge afterwards.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_hold", {24'd0, out_q}, 32'h0);
        @(posedge clk);
        #1;
        check("release_out_q", {24'd0, out_q}, 32'h3C);
        check("release_sel_q", {30'd0, sel_q}, 32'h1);

        // Edge data: channels alternate all-ones/all-zeros, both phases, every width.
        for (int p = 0; p < 2; p++) begin
            logic [31:0] v [4];
            for (int k = 0; k < 4; k++)
                v[k] = (((k + p) % 2) == 0) ? 32'hFFFF_FFFF : 32'h0;
            in0 = v[0][7:0]; in1 = v[1][7:0]; in2 = v[2][7:0]; in3 = v[3][7:0];
            n_in0 = v[0][0:0]; n_in1 = v[1][0:0]; n_in2 = v[2][0:0]; n_in3 = v[3][0:0];
            w_in0 = v[0]; w_in1 = v[1]; w_in2 = v[2]; w_in3 = v[3];
            for (int s = 0; s < 4; s++) begin
                sel = 2'(s); n_sel = 2'(s); w_sel = 2'(s);
                push($sformatf("edge8_p%0d_s%0d", p, s), {24'd0, v[s][7:0]});
                push($sformatf("edge1_p%0d_s%0d", p, s), {31'd0, v[s][0]});
                push($sformatf("edge32_p%0d_s%0d", p, s), v[s]);
                #5;
                pop_check({24'd0, out});
                pop_check({31'd0, n_out});
                pop_check(w_out);
            end
        end

        // Registered copy on the wide and narrow instances.
        @(negedge clk);
        w_sel = 2'b11; w_in3 = 32'hDEAD_BEEF;
        n_sel = 2'b10; n_in2 = 1'b1;
        push("w32_out_q", 32'hDEAD_BEEF);
        push("w1_out_q", 32'h1);
        @(posedge clk);
        #1;
        pop_check(w_out_q);
        pop_check({31'd0, n_out_q});
        check("w32_sel_q", {30'd0, w_sel_q}, 32'h3);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
